// File: rtl/alu_seq_if.sv
// Handshake and result bundle between the sequential ALU and its requester.
interface alu_seq_if #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         aluk;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [SHAMT_W-1:0] shamt;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic [2:0]         nzp;

    modport slave (
        input  in_valid, aluk, a, b, shamt, out_ready,
        output in_ready, out_valid, result, nzp
    );

    modport master (
        output in_valid, aluk, a, b, shamt, out_ready,
        input  in_ready, out_valid, result, nzp
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked LC-3b ALU with iterative one-bit-per-cycle shifts, registered
// result, NZP condition codes and a tristate datapath bus driver.
module alu_seq #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    alu_seq_if.slave         bus,
    input  logic             gate_alu,
    output logic [WIDTH-1:0] out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [2:0]         nzp_q, nzp_d;

    logic in_ready_s;
    logic out_valid_s;
    logic accept_s;
    logic retire_s;
    logic is_shift_s;
    logic start_shift_s;

    function automatic logic [WIDTH-1:0] alu_fn(input logic [2:0] op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        case (op)
            3'b000:  alu_fn = x + y;
            3'b001:  alu_fn = x & y;
            3'b010:  alu_fn = x ^ y;
            default: alu_fn = x;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] shift_step(input logic [2:0] op,
                                                    input logic [WIDTH-1:0] v);
        case (op)
            3'b100:  shift_step = {v[WIDTH-2:0], 1'b0};
            3'b101:  shift_step = {1'b0, v[WIDTH-1:1]};
            3'b110:  shift_step = {v[WIDTH-1], v[WIDTH-1:1]};
            default: shift_step = v;
        endcase
    endfunction

    function automatic logic [2:0] nzp_fn(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            nzp_fn = 3'b100;
        end else if (v == {WIDTH{1'b0}}) begin
            nzp_fn = 3'b010;
        end else begin
            nzp_fn = 3'b001;
        end
    endfunction

    assign is_shift_s    = (bus.aluk == 3'b100) || (bus.aluk == 3'b101) || (bus.aluk == 3'b110);
    assign start_shift_s = is_shift_s && (bus.shamt != {SHAMT_W{1'b0}});
    assign accept_s      = bus.in_valid && in_ready_s;
    assign retire_s      = out_valid_s && bus.out_ready;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            result_q <= {WIDTH{1'b0}};
            cnt_q    <= {SHAMT_W{1'b0}};
            op_q     <= 3'b000;
            nzp_q    <= 3'b010;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            nzp_q    <= nzp_d;
        end
    end

    // Next-state logic; a retire with a waiting request re-enters without a bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = start_shift_s ? S_SHIFT : S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (cnt_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                if (accept_s) begin
                    state_d = start_shift_s ? S_SHIFT : S_DONE;
                end else if (retire_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: load on accept, shift one bit per SHIFT cycle, flags on retire.
    always_comb begin
        result_d = result_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        nzp_d    = nzp_q;
        if (retire_s) begin
            nzp_d = nzp_fn(result_q);
        end else begin
            nzp_d = nzp_q;
        end
        if (state_q == S_SHIFT) begin
            result_d = shift_step(op_q, result_q);
            cnt_d    = cnt_q - {{(SHAMT_W-1){1'b0}}, 1'b1};
        end else if (accept_s) begin
            op_d = bus.aluk;
            if (start_shift_s) begin
                result_d = bus.a;
                cnt_d    = bus.shamt;
            end else begin
                result_d = alu_fn(bus.aluk, bus.a, bus.b);
                cnt_d    = {SHAMT_W{1'b0}};
            end
        end else begin
            result_d = result_q;
        end
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
            S_SHIFT: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
            S_DONE: begin
                in_ready_s  = bus.out_ready;
                out_valid_s = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.result    = result_q;
    assign bus.nzp       = nzp_q;
    assign out           = gate_alu ? result_q : {WIDTH{1'bz}};

endmodule
